control_jugador: RTL and testbench
==================================

Name: control_jugador

Overview:
- Command generator that drives the player-position block's `der`/`izq` move inputs from raw board push-buttons.
- Per-button path: synchronise, then debounce.
- Produces one single-cycle move pulse on press, then auto-repeat pulses while the button is held.
- Gates each pulse with the player block's `espacioAr`/`espacioAb` room flags so the player never steps past its limits.
- Sits between the button pins and the player block in the game top level.

Parameters:
- CNT_W, 24, width of all timing counters.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a button level change (10 ms at 25 MHz).
- REPEAT_DELAY, 6250000, cycles from first pulse to first auto-repeat pulse (250 ms).
- REPEAT_PERIOD, 625000, cycles between auto-repeat pulses (25 ms).
- ACCEL_AFTER, 8, repeat pulses before acceleration; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_der  in  1  raw right button, asynchronous, active-high
- btn_izq  in  1  raw left button, asynchronous, active-high
- espacioAr  in  1  from player block: 1 = room to move right
- espacioAb  in  1  from player block: 1 = room to move left
- der  out  1  registered one-cycle move-right pulse
- izq  out  1  registered one-cycle move-left pulse
- dir_activa  out  2  registered current debounced direction: 00 none, 01 der, 10 izq

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset is synchronous and active-high on `reset`.
  - Reset clears: `der`, `izq`, `dir_activa`, sync flops, debounced levels, all counters, FSM to IDLE.
- Synchroniser: each button passes through a 2-FF synchroniser.
- Debouncer (per button):
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. At DEBOUNCE_CYCLES it updates the debounced level and clears.
  - Latency from raw edge to debounced change: 2 + DEBOUNCE_CYCLES cycles.
- Direction:
  - der only → 01; izq only → 10.
  - Both or neither → 00. Simultaneous presses cancel.
  - `dir_activa` is this value, registered.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE, dir ≠ 00: emit pulse, latch dir, counter ← REPEAT_DELAY−1, go to DELAY.
  - DELAY / REPEAT, dir ≠ latched dir (release, cancel, or swap): outputs 0, go to IDLE. There is no pulse in that cycle. A swap therefore produces a fresh first pulse one cycle later.
  - DELAY / REPEAT, counter == 0: emit pulse, counter ← REPEAT_PERIOD−1, go to (or stay in) REPEAT.
  - Otherwise: counter decrements.
- Pulse spacing: REPEAT_DELAY cycles from first to second pulse, REPEAT_PERIOD cycles thereafter.
- Emit:
  - `der` ← (latched dir == 01) & `espacioAr`.
  - `izq` ← (latched dir == 10) & `espacioAb`.
  - Both outputs are registered and high for exactly one cycle.
  - A pulse suppressed by a room flag still advances timing; pulses resume on the next repeat slot once room returns.
  - `der` and `izq` are never high together.
- Room flags are sampled only in the emit cycle. There is no internal position tracking.

Optional Feature:
- Macro `CONTROL_JUGADOR_ACCEL_EN`.
- Defined:
  - Saturating counter of repeat pulses emitted in REPEAT.
  - After ACCEL_AFTER pulses, the reload becomes max(REPEAT_PERIOD>>1, 1) − 1.
  - The counter clears on return to IDLE or on reset.
- Undefined: constant REPEAT_PERIOD; no accel counter logic is present.

Decomposition:
- Package `jugador_pkg`:
  - FSM state encoding (IDLE=0, DELAY=1, REPEAT=2).
  - Direction codes DIR_NONE/DIR_DER/DIR_IZQ.
  - Default timing constants.
- Sub-module `antirrebote`: 2-FF synchroniser plus debounce counter. Parameters CNT_W and DEBOUNCE_CYCLES; ports `clk`, `reset`, `btn_in`, `btn_out`. Instantiated twice.
- FSM and emit logic live in `control_jugador`.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; `espacioAr` = `espacioAb` = 1 unless stated. Edge numbers below are counted from the `btn_der` rise.
- Single press: `btn_der` rises and holds 30 cycles → `der` pulses at edges 7, 17, 20, 23, 26, 29. `izq` stays 0 throughout. `dir_activa` = 01 from edge 7.
- Bounce: `btn_der` toggles every 2 cycles for 12 cycles, then stays 0 → no `der` pulse and `dir_activa` stays 00. Repeat with a final stable 1 → exactly one first pulse, 7 cycles after the last edge.
- Cancel: hold `btn_der`; after the first pulse also press `btn_izq` → both outputs 0 once izq is debounced. Release `btn_der` → `izq` first pulse one cycle after the debounced change.
- Boundary: hold `btn_der` with `espacioAr`=0 → no `der` pulses. Raise `espacioAr` mid-hold → `der` resumes on the next 3-cycle slot with no restart of REPEAT_DELAY.
- Reset mid-repeat: assert `reset` for one cycle while in REPEAT → next cycle all outputs 0 and FSM IDLE. With the button still held, the first pulse comes 7 cycles after `reset` deasserts.
- ACCEL (`CONTROL_JUGADOR_ACCEL_EN`, ACCEL_AFTER=2): hold `btn_der` → repeat spacing is 3, 3, then 1 cycle for all further pulses.

Source files
------------

// File: rtl/jugador_pkg.sv
// Shared definitions for the player command generator.
// Holds the FSM state encoding, the direction codes used on dir_activa
// and the default timing constants (25 MHz board clock).
// Optional feature macro used by the design: CONTROL_JUGADOR_ACCEL_EN.
package jugador_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_DER  = 2'b01;
  localparam logic [1:0] DIR_IZQ  = 2'b10;

  localparam int DEF_CNT_W           = 24;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 6250000;
  localparam int DEF_REPEAT_PERIOD   = 625000;
  localparam int DEF_ACCEL_AFTER     = 8;

endpackage

// File: rtl/control_jugador_antirrebote.sv
// antirrebote: 2-FF synchroniser followed by a debounce counter.
// Ports:
//   clk     - system clock
//   reset   - synchronous, active-high reset
//   btn_in  - raw asynchronous button level
//   btn_out - debounced level, changes 2 + DEBOUNCE_CYCLES cycles after
//             a stable raw change
module antirrebote #(
  parameter int CNT_W           = 24,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The counter only runs while the synced level disagrees with the accepted
  // level; any agreement restarts it, so only an unbroken run is accepted.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser chain and debounce state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_out = level_q;

endmodule

// File: rtl/control_jugador.sv
// control_jugador: turns the raw right/left push-buttons into one-cycle
// der/izq move pulses for the player block, with auto-repeat while held.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   btn_der, btn_izq    - raw asynchronous buttons
//   espacioAr/espacioAb - room flags from the player block (right/left)
//   der, izq            - registered one-cycle move pulses
//   dir_activa          - registered debounced direction (00/01/10)
// Optional feature: define CONTROL_JUGADOR_ACCEL_EN to halve the repeat
// period after ACCEL_AFTER repeat pulses.
module control_jugador
  import jugador_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`ifdef CONTROL_JUGADOR_ACCEL_EN
  , parameter int ACCEL_AFTER   = DEF_ACCEL_AFTER
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_der,
  input  logic       btn_izq,
  input  logic       espacioAr,
  input  logic       espacioAb,
  output logic       der,
  output logic       izq,
  output logic [1:0] dir_activa
);

  localparam logic [CNT_W-1:0] DELAY_RELOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_RELOAD = CNT_W'(REPEAT_PERIOD - 1);

  logic             derDeb, izqDeb;
  logic [1:0]       dirNow;
  state_t           state_q, state_d;
  logic [1:0]       dirLatch_q, dirLatch_d, dirActiva_q;
  logic [CNT_W-1:0] timer_q, timer_d, reload;
  logic             der_q, der_d, izq_q, izq_d, emit;

  antirrebote #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebDer (
    .clk(clk), .reset(reset), .btn_in(btn_der), .btn_out(derDeb)
  );

  antirrebote #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebIzq (
    .clk(clk), .reset(reset), .btn_in(btn_izq), .btn_out(izqDeb)
  );

  // Both buttons together cancel each other out.
  always_comb begin
    dirNow = DIR_NONE;
    if (derDeb && !izqDeb) dirNow = DIR_DER;
    if (izqDeb && !derDeb) dirNow = DIR_IZQ;
  end

`ifdef CONTROL_JUGADOR_ACCEL_EN
  localparam int HALF_PERIOD = ((REPEAT_PERIOD >> 1) > 0) ? (REPEAT_PERIOD >> 1) : 1;
  localparam logic [CNT_W-1:0] FAST_RELOAD = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] ACCEL_LIM   = CNT_W'(ACCEL_AFTER);

  logic [CNT_W-1:0] accelCnt_q, accelCnt_d;

  // The count seen here excludes the pulse being emitted now, so the first
  // ACCEL_AFTER repeat pulses are still followed by the full period.
  assign reload = (accelCnt_q >= ACCEL_LIM) ? FAST_RELOAD : PERIOD_RELOAD;
`else
  assign reload = PERIOD_RELOAD;
`endif

  // State register plus every other registered value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dirLatch_q  <= DIR_NONE;
      dirActiva_q <= DIR_NONE;
      timer_q     <= '0;
      der_q       <= 1'b0;
      izq_q       <= 1'b0;
`ifdef CONTROL_JUGADOR_ACCEL_EN
      accelCnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dirLatch_q  <= dirLatch_d;
      dirActiva_q <= dirNow;
      timer_q     <= timer_d;
      der_q       <= der_d;
      izq_q       <= izq_d;
`ifdef CONTROL_JUGADOR_ACCEL_EN
      accelCnt_q  <= accelCnt_d;
`endif
    end
  end

  // Next-state logic: any change of direction (release, cancel or swap)
  // drops back to IDLE, which gives a swap its fresh first pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dirNow != DIR_NONE) state_d = DELAY;
      end
      DELAY, REPEAT: begin
        if (dirNow != dirLatch_q) state_d = IDLE;
        else if (timer_q == '0)   state_d = REPEAT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic. A pulse blocked by a room flag still reloads
  // the timer, so the repeat cadence is never restarted by a wall.
  always_comb begin
    emit       = 1'b0;
    dirLatch_d = dirLatch_q;
    timer_d    = timer_q;
`ifdef CONTROL_JUGADOR_ACCEL_EN
    accelCnt_d = accelCnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (dirNow != DIR_NONE) begin
          emit       = 1'b1;
          dirLatch_d = dirNow;
          timer_d    = DELAY_RELOAD;
        end
      end
      DELAY, REPEAT: begin
        if (dirNow != dirLatch_q) begin
          dirLatch_d = DIR_NONE;
          timer_d    = '0;
`ifdef CONTROL_JUGADOR_ACCEL_EN
          accelCnt_d = '0;
`endif
        end else if (timer_q == '0) begin
          emit    = 1'b1;
          timer_d = reload;
`ifdef CONTROL_JUGADOR_ACCEL_EN
          if (accelCnt_q < ACCEL_LIM) accelCnt_d = accelCnt_q + 1'b1;
`endif
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        dirLatch_d = DIR_NONE;
        timer_d    = '0;
      end
    endcase
    der_d = emit && (dirLatch_d == DIR_DER) && espacioAr;
    izq_d = emit && (dirLatch_d == DIR_IZQ) && espacioAb;
  end

  assign der        = der_q;
  assign izq        = izq_q;
  assign dir_activa = dirActiva_q;

endmodule

// File: tb/tb_control_jugador.sv
// Directed testbench for control_jugador with short timing parameters.
// Edge numbers are counted from the cycle in which the button changes.
module tb_control_jugador;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnDer, btnIzq, espAr, espAb;
  logic       der, izq;
  logic [1:0] dirActiva;

  int checks = 0;
  int errors = 0;

  control_jugador #(
    .CNT_W(8),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
`ifdef CONTROL_JUGADOR_ACCEL_EN
    , .ACCEL_AFTER(2)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_der(btnDer),
    .btn_izq(btnIzq),
    .espacioAr(espAr),
    .espacioAb(espAb),
    .der(der),
    .izq(izq),
    .dir_activa(dirActiva)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it before sampling.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic i, input logic ar, input logic ab);
    btnDer = d;
    btnIzq = i;
    espAr  = ar;
    espAb  = ab;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Expected der pulse at edge e of a sustained press with room available.
  function automatic logic [31:0] expDer(input int e);
`ifdef CONTROL_JUGADOR_ACCEL_EN
    return (e == 7 || e == 17 || e == 20 || e >= 23) ? 32'd1 : 32'd0;
`else
    return (e == 7 || (e >= 17 && (e - 17) % 3 == 0)) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic settle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (12) waitCycle();
  endtask

  // Bouncing phase: six 2-cycle phases starting high, ending low.
  task automatic bounce(input string tag);
    for (int p = 0; p < 6; p++) begin
      applyStimulus((p % 2 == 0), 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 2; c++) begin
        waitCycle();
        checkOutput($sformatf("%s der p%0d", tag, p), der, 0);
        checkOutput($sformatf("%s dir p%0d", tag, p), dirActiva, 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) waitCycle();
    checkOutput("rst der", der, 0);
    checkOutput("rst izq", izq, 0);
    checkOutput("rst dir", dirActiva, 0);
    reset = 1'b0;
    repeat (3) waitCycle();

    // Single sustained press.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    for (int e = 1; e <= 30; e++) begin
      waitCycle();
      checkOutput($sformatf("single der@%0d", e), der, expDer(e));
      checkOutput($sformatf("single izq@%0d", e), izq, 0);
      checkOutput($sformatf("single dir@%0d", e), dirActiva, (e >= 7) ? 1 : 0);
    end
    settle();

    // Bounce that settles low: nothing must come out.
    bounce("bounceLow");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int e = 1; e <= 10; e++) begin
      waitCycle();
      checkOutput($sformatf("bounceLow der@%0d", e), der, 0);
      checkOutput($sformatf("bounceLow dir@%0d", e), dirActiva, 0);
    end
    settle();

    // Bounce that settles high: one first pulse 7 edges after the last rise.
    bounce("bounceHigh");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    for (int e = 1; e <= 12; e++) begin
      waitCycle();
      checkOutput($sformatf("bounceHigh der@%0d", e), der, (e == 7) ? 1 : 0);
    end
    settle();

    // Cancel with both buttons, then release der to leave izq alone.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    for (int e = 1; e <= 30; e++) begin
      waitCycle();
      checkOutput($sformatf("cancel der@%0d", e), der, (e == 7) ? 1 : 0);
      checkOutput($sformatf("cancel izq@%0d", e), izq, (e == 29) ? 1 : 0);
      checkOutput($sformatf("cancel dir@%0d", e), dirActiva,
                  (e < 7) ? 0 : (e <= 14) ? 1 : (e <= 28) ? 0 : 2);
      if (e == 8)  applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      if (e == 22) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    end
    settle();

    // Wall on the right, opened mid-hold: cadence continues unchanged.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 27; e++) begin
      waitCycle();
      checkOutput($sformatf("wall der@%0d", e), der, (e >= 22) ? expDer(e) : 0);
      if (e == 21) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    end
    settle();

    // Reset in the middle of auto-repeat with the button still held.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    for (int e = 1; e <= 21; e++) begin
      waitCycle();
      if (e == 20) checkOutput("midrst der@20", der, expDer(20));
    end
    reset = 1'b1;
    waitCycle();
    checkOutput("midrst der", der, 0);
    checkOutput("midrst izq", izq, 0);
    checkOutput("midrst dir", dirActiva, 0);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      waitCycle();
      checkOutput($sformatf("postrst der@%0d", e), der, (e == 7) ? 1 : 0);
      checkOutput($sformatf("postrst izq@%0d", e), izq, 0);
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
